l1_sst_gain_bank: RTL

//  Multi-channel successor to the single-channel L1 SST+ apical-gain path. Each channel's

---
 rtl/l1_sst_gain_bank_if.sv | 31 +++
 rtl/l1_sst_gain_bank.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/l1_sst_gain_bank_if.sv
// Bundle of sweep-control, per-channel drive inputs and gain outputs for l1_sst_gain_bank.
// Latency: none (wiring only).
// Backpressure: none; the sweep strobe is fire-and-forget and the busy/overrun flags report collisions.
interface l1_sst_gain_bank_if #(
    parameter int WIDTH = 18,
    parameter int NCH   = 4
);
    logic                   clk_en;
    logic                   flush;
    logic [NCH*WIDTH-1:0]   matrix_in;
    logic [NCH*WIDTH-1:0]   fb1_in;
    logic [NCH*WIDTH-1:0]   fb2_in;
    logic [NCH-1:0]         bypass;
    logic                   overrun_clr;
    logic [NCH*WIDTH-1:0]   gain_out;
    logic                   gain_valid;
    logic                   busy;
    logic                   overrun;

    // Source side: sweep strobe and drive inputs out, gains and status in.
    modport master (
        output clk_en, flush, matrix_in, fb1_in, fb2_in, bypass, overrun_clr,
        input  gain_out, gain_valid, busy, overrun
    );

    // Gain bank side.
    modport slave (
        input  clk_en, flush, matrix_in, fb1_in, fb2_in, bypass, overrun_clr,
        output gain_out, gain_valid, busy, overrun
    );
endinterface

// File: rtl/l1_sst_gain_bank.sv
// Multi-channel SST+ apical gain: weighted drive -> rise/decay leaky integrator -> clamped 1.0+state gain.
// Latency: lane k updates k+1 clks after clk_en; gain_valid pulses NCH+1 clks after clk_en.
// Backpressure: none; clk_en while a sweep is active is dropped and latches the sticky overrun flag.
module l1_sst_gain_bank #(
    parameter int WIDTH           = 18,
    parameter int FRAC            = 14,
    parameter int NCH             = 4,
    parameter int TAU_RISE_SHIFT  = 7,
    parameter int TAU_DECAY_SHIFT = 7,
    parameter int W_MTX           = 4915,
    parameter int W_FB1           = 4915,
    parameter int W_FB2           = 4915,
    parameter int GAIN_MIN        = 4096,
    parameter int GAIN_MAX        = 32768
) (
    input  logic                 clk,
    input  logic                 rst,
    l1_sst_gain_bank_if.slave    bus
);

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW   = 2 * WIDTH;
    localparam int SUMW = 2 * WIDTH + 2;

    localparam logic [CH_W-1:0]        CH_LAST  = CH_W'(NCH - 1);
    localparam logic signed [PW-1:0]   W_M_X    = PW'(W_MTX);
    localparam logic signed [PW-1:0]   W_F1_X   = PW'(W_FB1);
    localparam logic signed [PW-1:0]   W_F2_X   = PW'(W_FB2);
    localparam logic signed [SUMW-1:0] D_MAX    = SUMW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
    localparam logic signed [SUMW-1:0] D_MIN    = -D_MAX;
    localparam logic signed [WIDTH+1:0] S_MAX   = (WIDTH + 2)'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
    localparam logic signed [WIDTH+1:0] S_MIN   = -S_MAX;
    localparam logic signed [WIDTH:0]  G_ONE    = (WIDTH + 1)'(64'sd1 <<< FRAC);
    localparam logic signed [WIDTH:0]  G_MIN    = (WIDTH + 1)'(GAIN_MIN);
    localparam logic signed [WIDTH:0]  G_MAX    = (WIDTH + 1)'(GAIN_MAX);
    localparam logic [WIDTH-1:0]       ONE_LANE = WIDTH'(64'sd1 <<< FRAC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } fsm_t;

    fsm_t                      fsm_q, fsm_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic [NCH*WIDTH-1:0]      mtx_snap_q, mtx_snap_d;
    logic [NCH*WIDTH-1:0]      fb1_snap_q, fb1_snap_d;
    logic [NCH*WIDTH-1:0]      fb2_snap_q, fb2_snap_d;
    logic [NCH-1:0]            byp_snap_q, byp_snap_d;
    logic signed [WIDTH-1:0]   st_q [NCH];
    logic signed [WIDTH-1:0]   st_d [NCH];
    logic [NCH*WIDTH-1:0]      gain_q, gain_d;
    logic                      gain_valid_q, gain_valid_d;
    logic                      busy_q, busy_d;
    logic                      overrun_q, overrun_d;

    // Datapath for the channel currently addressed by ch_q.
    logic signed [WIDTH-1:0]   m_sel, f1_sel, f2_sel;
    logic                      byp_sel;
    logic signed [PW-1:0]      m_x, f1_x, f2_x;
    logic signed [PW-1:0]      p_m, p_f1, p_f2;
    logic signed [SUMW-1:0]    sum, sum_sh;
    logic signed [WIDTH-1:0]   drv;
    logic signed [WIDTH-1:0]   s_cur;
    logic signed [WIDTH:0]     diff, step;
    logic signed [WIDTH+1:0]   acc;
    logic signed [WIDTH-1:0]   filt, s_new;
    logic signed [WIDTH:0]     g_raw, g_clamp;
    logic [WIDTH-1:0]          g_lane;

    // Drive, leaky integrator step and gain clamp for one channel per clk.
    always_comb begin
        m_sel   = mtx_snap_q[int'(ch_q)*WIDTH +: WIDTH];
        f1_sel  = fb1_snap_q[int'(ch_q)*WIDTH +: WIDTH];
        f2_sel  = fb2_snap_q[int'(ch_q)*WIDTH +: WIDTH];
        byp_sel = byp_snap_q[ch_q];

        m_x  = {{WIDTH{m_sel[WIDTH-1]}},  m_sel};
        f1_x = {{WIDTH{f1_sel[WIDTH-1]}}, f1_sel};
        f2_x = {{WIDTH{f2_sel[WIDTH-1]}}, f2_sel};
        p_m  = m_x  * W_M_X;
        p_f1 = f1_x * W_F1_X;
        p_f2 = f2_x * W_F2_X;

        // Two guard bits keep the three-term sum exact before scaling back to Q.FRAC.
        sum    = {{2{p_m[PW-1]}}, p_m} + {{2{p_f1[PW-1]}}, p_f1} + {{2{p_f2[PW-1]}}, p_f2};
        sum_sh = sum >>> FRAC;
        if (sum_sh > D_MAX) begin
            drv = D_MAX[WIDTH-1:0];
        end else if (sum_sh < D_MIN) begin
            drv = D_MIN[WIDTH-1:0];
        end else begin
            drv = sum_sh[WIDTH-1:0];
        end

        // Rising and falling error use separate time constants; floor shift means a
        // positive residual below 2^TAU_RISE_SHIFT stalls, a negative one always moves.
        s_cur = st_q[ch_q];
        diff  = {drv[WIDTH-1], drv} - {s_cur[WIDTH-1], s_cur};
        if (!diff[WIDTH] && (diff != '0)) begin
            step = diff >>> TAU_RISE_SHIFT;
        end else begin
            step = diff >>> TAU_DECAY_SHIFT;
        end
        acc = {{2{s_cur[WIDTH-1]}}, s_cur} + {step[WIDTH], step};
        if (acc > S_MAX) begin
            filt = S_MAX[WIDTH-1:0];
        end else if (acc < S_MIN) begin
            filt = S_MIN[WIDTH-1:0];
        end else begin
            filt = acc[WIDTH-1:0];
        end
        s_new = byp_sel ? drv : filt;

        // Gain is 1.0 + state; only the output is clamped, the state keeps its full range.
        g_raw = {s_new[WIDTH-1], s_new} + G_ONE;
        if (g_raw > G_MAX) begin
            g_clamp = G_MAX;
        end else if (g_raw < G_MIN) begin
            g_clamp = G_MIN;
        end else begin
            g_clamp = g_raw;
        end
        g_lane = g_clamp[WIDTH-1:0];
    end

    // Sweep sequencing, snapshot capture, state/lane write-back and status flags.
    always_comb begin
        fsm_d        = fsm_q;
        ch_d         = ch_q;
        mtx_snap_d   = mtx_snap_q;
        fb1_snap_d   = fb1_snap_q;
        fb2_snap_d   = fb2_snap_q;
        byp_snap_d   = byp_snap_q;
        st_d         = st_q;
        gain_d       = gain_q;
        gain_valid_d = 1'b0;
        busy_d       = busy_q;
        overrun_d    = overrun_q;

        if (bus.overrun_clr) begin
            overrun_d = 1'b0;
        end
        // A collision set overrides a same-clk clear; flush swallows the strobe entirely.
        if (bus.clk_en && !bus.flush && (fsm_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        if (bus.flush) begin
            fsm_d  = ST_IDLE;
            ch_d   = '0;
            busy_d = 1'b0;
            gain_d = {NCH{ONE_LANE}};
            for (int k = 0; k < NCH; k++) begin
                st_d[k] = '0;
            end
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (bus.clk_en) begin
                        // Freeze inputs so every lane of one sweep sees the same instant.
                        mtx_snap_d = bus.matrix_in;
                        fb1_snap_d = bus.fb1_in;
                        fb2_snap_d = bus.fb2_in;
                        byp_snap_d = bus.bypass;
                        ch_d       = '0;
                        busy_d     = 1'b1;
                        fsm_d      = ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    st_d[ch_q] = s_new;
                    gain_d[int'(ch_q)*WIDTH +: WIDTH] = g_lane;
                    if (ch_q == CH_LAST) begin
                        fsm_d = ST_DONE;
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end
                ST_DONE: begin
                    gain_valid_d = 1'b1;
                    busy_d       = 1'b0;
                    fsm_d        = ST_IDLE;
                end
                default: begin
                    fsm_d  = ST_IDLE;
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    // All state and registered outputs; reset parks every lane at unity gain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q        <= ST_IDLE;
            ch_q         <= '0;
            mtx_snap_q   <= '0;
            fb1_snap_q   <= '0;
            fb2_snap_q   <= '0;
            byp_snap_q   <= '0;
            for (int k = 0; k < NCH; k++) begin
                st_q[k] <= '0;
            end
            gain_q       <= {NCH{ONE_LANE}};
            gain_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            ch_q         <= ch_d;
            mtx_snap_q   <= mtx_snap_d;
            fb1_snap_q   <= fb1_snap_d;
            fb2_snap_q   <= fb2_snap_d;
            byp_snap_q   <= byp_snap_d;
            for (int k = 0; k < NCH; k++) begin
                st_q[k] <= st_d[k];
            end
            gain_q       <= gain_d;
            gain_valid_q <= gain_valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.gain_out   = gain_q;
    assign bus.gain_valid = gain_valid_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;

endmodule
